// File: rtl/gpio_exp_pkg.sv
// ============================================================================
// Package  : gpio_exp_pkg
// Brief    : Shared FSM encodings and SPI frame geometry for the GPIO expander.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package gpio_exp_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;
  localparam int RW_BIT     = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } spi_state_t;

  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_SETUP  = 2'd1,
    A_ACCESS = 2'd2
  } apb_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_apb_bridge_if.sv
// ============================================================================
// Interface: spi_apb_bridge_if
// Brief    : APB bus between the SPI bridge (master) and the GPIO register block.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface spi_apb_bridge_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic                  pselx;
  logic                  penable;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;

  modport master (
    output paddr, pwrite, pselx, penable, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  paddr, pwrite, pselx, penable, pwdata,
    output prdata, pready
  );
endinterface

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Brief    : Parameterised-width two-flop synchroniser with per-bit reset value.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_2ff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/spi_apb_bridge.sv
// ============================================================================
// Module   : spi_apb_bridge
// Brief    : SPI mode-0 slave that turns each 16-bit frame into one APB transfer.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_apb_bridge
  import gpio_exp_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 3,
  parameter int PREADY_TIMEOUT = 15
) (
  input  logic pclk,
  input  logic presetn,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic busy,
  spi_apb_bridge_if.master apb
);

  localparam int c_wait_w = $clog2(PREADY_TIMEOUT + 1);

  // cs_n resets high so the pad stays tristated and no false frame start is seen
  logic [2:0] w_sync;
  sync_2ff #(.WIDTH(3), .RESET_VAL(3'b010)) u_sync (
    .pclk    (pclk),
    .presetn (presetn),
    .i_d     ({sclk, cs_n, mosi}),
    .o_q     (w_sync)
  );

  logic w_sclk_s, w_cs_s, w_mosi_s;
  logic r_sclk_d, r_cs_d;
  logic w_rise, w_fall, w_cs_start, w_cs_end;

  assign w_sclk_s = w_sync[2];
  assign w_cs_s   = w_sync[1];
  assign w_mosi_s = w_sync[0];

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b1;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_cs_d   <= w_cs_s;
    end
  end

  assign w_rise     =  w_sclk_s & ~r_sclk_d;
  assign w_fall     = ~w_sclk_s &  r_sclk_d;
  assign w_cs_start = ~w_cs_s   &  r_cs_d;
  assign w_cs_end   =  w_cs_s   & ~r_cs_d;

  spi_state_t r_sstate, w_sstate_nxt;
  apb_state_t r_astate, w_astate_nxt;

  logic [FRAME_BITS-2:0] r_rx;
  logic [FRAME_BITS-1:0] w_rx_nxt;
  logic [4:0]            r_bit_cnt;
  logic [4:0]            r_fall_cnt;
  logic                  r_is_write;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rd_buf;
  logic                  r_err;
  logic                  r_err_rep;

  logic                  w_cmd_done;
  logic                  w_launch;
  logic                  w_launch_wr;
  logic [ADDR_WIDTH-1:0] w_launch_addr;
  logic [DATA_WIDTH-1:0] w_launch_data;
  logic                  w_done;
  logic                  w_abort;
  logic                  w_err_evt;

  logic [c_wait_w-1:0]   r_wait_cnt;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;

  assign w_rx_nxt = {r_rx, w_mosi_s};

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_sstate <= S_IDLE;
    end else begin
      r_sstate <= w_sstate_nxt;
    end
  end

  // A rise is acted on before cs_end, so a 16th rise coinciding with cs_end still launches
  always_comb begin
    w_sstate_nxt  = r_sstate;
    w_cmd_done    = 1'b0;
    w_launch      = 1'b0;
    w_launch_wr   = 1'b0;
    w_launch_addr = w_rx_nxt[ADDR_WIDTH-1:0];
    w_launch_data = '0;
    case (r_sstate)
      S_IDLE: begin
        if (w_cs_start) w_sstate_nxt = S_CMD;
      end
      S_CMD: begin
        if (w_rise && r_bit_cnt == 5'(CMD_BITS - 1)) begin
          w_cmd_done   = 1'b1;
          w_sstate_nxt = S_DATA;
          if (!w_rx_nxt[CMD_BITS-1]) w_launch = 1'b1;
        end
        if (w_cs_end) w_sstate_nxt = S_IDLE;
      end
      S_DATA: begin
        if (w_rise && r_bit_cnt == 5'(FRAME_BITS - 1)) begin
          w_sstate_nxt  = S_DONE;
          w_launch      = w_rx_nxt[RW_BIT];
          w_launch_wr   = 1'b1;
          w_launch_addr = w_rx_nxt[CMD_BITS +: ADDR_WIDTH];
          w_launch_data = w_rx_nxt[DATA_WIDTH-1:0];
        end
        if (w_cs_end) w_sstate_nxt = S_IDLE;
      end
      S_DONE: begin
        if (w_cs_end) w_sstate_nxt = S_IDLE;
      end
      default: w_sstate_nxt = S_IDLE;
    endcase
  end

  // Status byte shifts out during the command; the 8th fall swaps in the read data
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_rx       <= '0;
      r_bit_cnt  <= '0;
      r_fall_cnt <= '0;
      r_is_write <= 1'b0;
      r_tx       <= '0;
    end else if (r_sstate == S_IDLE) begin
      if (w_cs_start) begin
        r_rx       <= '0;
        r_bit_cnt  <= '0;
        r_fall_cnt <= '0;
        r_tx       <= {r_err, {(DATA_WIDTH-1){1'b0}}};
      end
    end else begin
      if (w_rise && r_sstate != S_DONE) begin
        r_rx      <= w_rx_nxt[FRAME_BITS-2:0];
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
      if (w_cmd_done) r_is_write <= w_rx_nxt[CMD_BITS-1];
      if (w_fall) begin
        r_fall_cnt <= r_fall_cnt + 5'd1;
        if (r_fall_cnt == 5'(CMD_BITS - 1)) begin
          r_tx <= r_is_write ? '0 : r_rd_buf;
        end else begin
          r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign miso    = r_tx[DATA_WIDTH-1];
  assign miso_oe = ~w_cs_s;

  // A fresh error is never cleared by the frame end that follows it unreported
  assign w_err_evt = w_abort | (w_launch & (r_astate != A_IDLE));

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_err     <= 1'b0;
      r_err_rep <= 1'b0;
    end else if (w_err_evt) begin
      r_err     <= 1'b1;
      r_err_rep <= 1'b0;
    end else if (r_sstate == S_IDLE && w_cs_start) begin
      r_err_rep <= r_err;
    end else if (w_cs_end && r_err_rep) begin
      r_err     <= 1'b0;
      r_err_rep <= 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_astate <= A_IDLE;
    end else begin
      r_astate <= w_astate_nxt;
    end
  end

  always_comb begin
    w_astate_nxt = r_astate;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_astate)
      A_IDLE: begin
        if (w_launch) w_astate_nxt = A_SETUP;
      end
      A_SETUP: begin
        w_astate_nxt = A_ACCESS;
      end
      A_ACCESS: begin
        if (apb.pready) begin
          w_done       = 1'b1;
          w_astate_nxt = A_IDLE;
        end else if (r_wait_cnt == c_wait_w'(PREADY_TIMEOUT - 1)) begin
          w_abort      = 1'b1;
          w_astate_nxt = A_IDLE;
        end
      end
      default: w_astate_nxt = A_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_wait_cnt <= '0;
      r_paddr    <= '0;
      r_pwrite   <= 1'b0;
      r_pwdata   <= '0;
      r_rd_buf   <= '0;
    end else begin
      r_wait_cnt <= (r_astate == A_ACCESS) ? r_wait_cnt + c_wait_w'(1) : '0;
      if (r_astate == A_IDLE && w_launch) begin
        r_paddr  <= w_launch_addr;
        r_pwrite <= w_launch_wr;
        r_pwdata <= w_launch_wr ? w_launch_data : '0;
      end
      if (w_done && !r_pwrite) begin
        r_rd_buf <= apb.prdata;
      end else if (w_abort && !r_pwrite) begin
        r_rd_buf <= '0;
      end
    end
  end

  assign apb.paddr   = r_paddr;
  assign apb.pwrite  = r_pwrite;
  assign apb.pwdata  = r_pwdata;
  assign apb.pselx   = (r_astate != A_IDLE);
  assign apb.penable = (r_astate == A_ACCESS);
  assign busy        = (r_astate != A_IDLE);

endmodule

`default_nettype wire

// File: doc/spi_apb_bridge.md
Name: spi_apb_bridge

Overview:
- SPI slave front end of the GPIO expander. Receives 16-bit SPI frames from an external host and turns each one into a single APB master transfer toward the GPIO register block.
- Sits directly upstream of the register block and drives its paddr/pwrite/pselx/penable/pwdata; consumes its prdata/pready.
- SPI lines are asynchronous to pclk. They are oversampled and edge-detected inside the block.

Parameters:
- DATA_WIDTH, 8, APB data width. Fixed at 8 because the frame format carries 8 data bits.
- ADDR_WIDTH, 3, APB address width; must be ≤ 7. paddr is the low ADDR_WIDTH bits of the 7-bit frame address.
- PREADY_TIMEOUT, 15, maximum pclk cycles spent in ACCESS waiting for pready before the transfer is aborted.

Ports:
- pclk  in  1  system clock; all logic on its rising edge.
- presetn  in  1  reset; one clock; synchronous, active-low.
- sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0); asynchronous.
- cs_n  in  1  SPI chip select, active-low; asynchronous.
- mosi  in  1  SPI data from host; asynchronous.
- miso  out  1  SPI data to host.
- miso_oe  out  1  miso output enable (pad tristate control).
- paddr  out  ADDR_WIDTH  APB address.
- pwrite  out  1  APB direction; 1 = write.
- pselx  out  1  APB select.
- penable  out  1  APB enable.
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- busy  out  1  high while an APB transfer is in flight.

Behaviour:
Reset (presetn low at a pclk edge):
- All outputs 0: miso, miso_oe, paddr, pwrite, pselx, penable, pwdata, busy.
- err flag 0; both FSMs to IDLE; shift registers and bit counter cleared.

Input synchronisation and edge detection:
- sclk, cs_n and mosi each pass through a 2-flop synchroniser, plus one delay flop on sclk and cs_n.
- rise = sclk_s & ~sclk_d; fall = ~sclk_s & sclk_d; cs_start = ~cs_s & cs_d; cs_end = cs_s & ~cs_d.
- Host constraint: SCLK high and low phases are each ≥ 8 pclk cycles.

Frame format, MSB first:
- bit15 = R/W (1 = write); bits14:8 = address; bits7:0 = write data. The data byte is don't-care for reads.

SPI FSM:
- S_IDLE → S_CMD on cs_start; bit counter := 0.
- S_CMD: shift mosi_s on each rise. After the 8th rise:
  - read: launch APB read; → S_DATA.
  - write: → S_DATA, no launch yet.
- S_DATA: after the 16th rise:
  - write: launch APB write with the captured data.
  - both: → S_DONE.
- S_DONE: rise edges ignored (extra bits discarded); → S_IDLE on cs_end.
- cs_end in S_CMD or S_DATA (short frame): → S_IDLE. No write is launched; a read already launched still completes on APB, but its data is discarded.

MISO:
- miso_oe = ~cs_s.
- During the command byte, miso shifts out the status byte {err, 7'b0}. Bit7 is presented on cs_start; later bits update on each fall.
- For reads, the tx register loads prdata when the APB read completes. Its MSB drives miso on the 8th fall; the remaining bits update on falls 9–15.
- For writes, miso = 0 during the data byte.
- err clears on the cs_end of any frame in which it was reported.

APB FSM:
- A_IDLE → A_SETUP on launch. In the same cycle, drive paddr, pwrite, pwdata (pwdata = 0 for reads); pselx=1, penable=0, busy=1.
- A_SETUP → A_ACCESS after exactly 1 cycle; penable=1.
- A_ACCESS:
  - on pready=1: capture prdata (read only); deassert pselx/penable; busy=0; → A_IDLE. Minimum transfer is 2 cycles.
  - on wait counter reaching PREADY_TIMEOUT with pready still 0: abort; deassert pselx/penable; set err; read data := 8'h00; → A_IDLE.
- paddr, pwrite and pwdata hold their values after the transfer ends, until the next launch.

Simultaneous events:
- A launch while busy cannot occur under the SCLK constraint. If it does, it is dropped and err is set.
- cs_end coinciding with the 16th rise: the rise is processed first, so the write is launched.

Decomposition:
- Shared package gpio_exp_pkg holds:
  - SPI FSM state encodings (S_IDLE, S_CMD, S_DATA, S_DONE) and APB FSM state encodings (A_IDLE, A_SETUP, A_ACCESS).
  - FRAME_BITS=16, CMD_BITS=8, RW_BIT=15.
- One sub-module: sync_2ff (parameterised-width 2-flop synchroniser), instantiated for sclk/cs_n/mosi.

Test Plan:
- Write frame 0x83A5 (W, addr 3, data A5) → exactly one APB write: paddr=3, pwdata=A5, pselx 2 cycles, penable 1 cycle. Launch follows the 16th rise by ≤ 4 pclk.
- Read frame 0x0400 with slave prdata=0x5A → APB read launched after 8th rise; miso on falls 8–15 = 0,1,0,1,1,0,1,0; status byte = 0x00.
- cs_n deasserted after 12 bits of a write frame → no pselx activity; next full frame behaves normally.
- Slave holds pready=0 → access aborted after 15 ACCESS cycles; busy drops; the next frame's first miso bit is 1; the frame after that reads status 0x00.
- 20-bit frame 0x81F0 followed by 4 extra bits → single write (addr 1, data F0); extra bits ignored.
- presetn low mid-frame, after 10 bits → all outputs 0 next cycle; partial frame discarded; a subsequent write completes correctly.
